// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master: FSM states, the
// queued command record and the sizing rule for the wait/timeout counter.
package apb_cmd_pkg;

  localparam int APB_ADDR_W   = 12;
  localparam int APB_DATA_W   = 32;
  localparam int TO_CNT_MIN_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } cmd_t;

  // Wait counter must hold TIMEOUT and is never narrower than 8 bits.
  function automatic int to_cnt_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > TO_CNT_MIN_W) ? w : TO_CNT_MIN_W;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command stream, response stream and APB bus signals of the command master.
// The master modport is the requester side; the slave modport is the
// environment (command source, response sink and APB completer).
interface apb_cmd_master_if #(
  parameter int ADDR_W = apb_cmd_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_cmd_pkg::APB_DATA_W
);

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;

  logic [ADDR_W-1:0] PADDR_o;
  logic [DATA_W-1:0] PWDATA_o;
  logic              PWRITE_o;
  logic              PSEL_o;
  logic              PENABLE_o;
  logic [DATA_W-1:0] PRDATA_i;
  logic              PREADY_i;
  logic              PSLVERR_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output PADDR_o, PWDATA_o, PWRITE_o, PSEL_o, PENABLE_o,
    input  PRDATA_i, PREADY_i, PSLVERR_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  PADDR_o, PWDATA_o, PWRITE_o, PSEL_o, PENABLE_o,
    output PRDATA_i, PREADY_i, PSLVERR_i
  );

endinterface

// File: rtl/apb_cmd_master_fifo.sv
// Synchronous first-word-fall-through FIFO of cmd_t. Full/empty are decoded
// from an occupancy count one bit wider than the pointers; pointers wrap
// naturally because the depth is a power of two.
module apb_cmd_fifo
  import apb_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  cmd_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == {CNT_W{1'b0}});
  assign rdata = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: queues register commands, runs each as an APB SETUP/ACCESS
// transfer with a PREADY timeout, and returns status/read data on a
// valid/ready response stream. All APB and response outputs come from flops.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W     = APB_ADDR_W,
  parameter int DATA_W     = APB_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_cmd_master_if.master bus,
  output logic             busy_o
);

  localparam int CNT_W = to_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [DATA_W-1:0] pwdata_r;
  logic              pwrite_r;
  logic              psel_r;
  logic              penable_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              rsp_timeout_r;
  logic              out_en_r;

  cmd_t              cmd_in_s;
  cmd_t              cmd_out_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  // Pack the incoming command stream into the queued record.
  always_comb begin
    cmd_in_s       = '0;
    cmd_in_s.write = bus.cmd_write_i;
    cmd_in_s.addr  = bus.cmd_addr_i;
    cmd_in_s.wdata = bus.cmd_wdata_i;
  end

  // Accept on handshake; pop whenever the FSM is free and work is queued.
  always_comb begin
    push_s = bus.cmd_valid_i && bus.cmd_ready_o;
    if ((state_r == IDLE) && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (cmd_in_s),
    .pop   (pop_s),
    .rdata (cmd_out_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Holds cmd_ready low while reset is asserted and for the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_r <= 1'b0;
    end else begin
      out_en_r <= 1'b1;
    end
  end

  // Transfer sequencer with its APB and response output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      wait_cnt_r    <= {CNT_W{1'b0}};
      paddr_r       <= {ADDR_W{1'b0}};
      pwdata_r      <= {DATA_W{1'b0}};
      pwrite_r      <= 1'b0;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            paddr_r  <= cmd_out_s.addr;
            pwdata_r <= cmd_out_s.wdata;
            pwrite_r <= cmd_out_s.write;
            psel_r   <= 1'b1;
            state_r  <= SETUP;
          end
        end
        SETUP: begin
          penable_r  <= 1'b1;
          wait_cnt_r <= {CNT_W{1'b0}};
          state_r    <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY_i) begin
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= bus.PSLVERR_i;
            rsp_timeout_r <= 1'b0;
            rsp_rdata_r   <= pwrite_r ? {DATA_W{1'b0}} : bus.PRDATA_i;
            state_r       <= RESP;
          end else if (wait_cnt_r == WAIT_LAST) begin
            // Completer never answered: abandon the transfer.
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            state_r       <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o   = out_en_r && !fifo_full_s;
  assign bus.rsp_valid_o   = rsp_valid_r;
  assign bus.rsp_rdata_o   = rsp_rdata_r;
  assign bus.rsp_err_o     = rsp_err_r;
  assign bus.rsp_timeout_o = rsp_timeout_r;
  assign bus.PADDR_o       = paddr_r;
  assign bus.PWDATA_o      = pwdata_r;
  assign bus.PWRITE_o      = pwrite_r;
  assign bus.PSEL_o        = psel_r;
  assign bus.PENABLE_o     = penable_r;
  assign busy_o            = !fifo_empty_s || (state_r != IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master.
module tb_apb_cmd_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  apb_cmd_master_if bus ();

  apb_cmd_master #(
    .ADDR_W     (12),
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .TIMEOUT    (255)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = 12'h000;
    bus.cmd_wdata_i = 32'h0;
    bus.rsp_ready_i = 1'b0;
    bus.PRDATA_i    = 32'h0;
    bus.PREADY_i    = 1'b0;
    bus.PSLVERR_i   = 1'b0;
  endtask

  task automatic push_cmd(input logic w, input logic [11:0] a, input logic [31:0] d, output bit ok);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready_o) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_psel(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.PSEL_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    checks++; if (bus.PSEL_o !== 1'b0) begin errors++; $display("FAIL rst_psel got %b exp 0", bus.PSEL_o); end
    checks++; if (bus.PENABLE_o !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", bus.PENABLE_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid_o); end
    checks++; if (bus.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", bus.cmd_ready_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (bus.PADDR_o !== 12'h000) begin errors++; $display("FAIL rst_paddr got %h exp 000", bus.PADDR_o); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", bus.cmd_ready_o); end
  endtask

  task automatic test_write();
    bus.PREADY_i    = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b1;
    bus.cmd_addr_i  = 12'h004;
    bus.cmd_wdata_i = 32'hDEADBEEF;
    checks++; if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", bus.cmd_ready_o); end
    tick();  // N+1
    bus.cmd_valid_i = 1'b0;
    checks++; if (bus.PSEL_o !== 1'b0) begin errors++; $display("FAIL wr_psel_n1 got %b exp 0", bus.PSEL_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_n1 got %b exp 1", busy); end
    tick();  // N+2
    checks++; if (bus.PSEL_o !== 1'b1 || bus.PENABLE_o !== 1'b0) begin errors++; $display("FAIL wr_setup got psel=%b pen=%b exp 1/0", bus.PSEL_o, bus.PENABLE_o); end
    checks++; if (bus.PADDR_o !== 12'h004 || bus.PWRITE_o !== 1'b1) begin errors++; $display("FAIL wr_addr got %h/%b exp 004/1", bus.PADDR_o, bus.PWRITE_o); end
    checks++; if (bus.PWDATA_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_pwdata got %h exp deadbeef", bus.PWDATA_o); end
    tick();  // N+3
    checks++; if (bus.PSEL_o !== 1'b1 || bus.PENABLE_o !== 1'b1) begin errors++; $display("FAIL wr_access got psel=%b pen=%b exp 1/1", bus.PSEL_o, bus.PENABLE_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_rsp_early got %b exp 0", bus.rsp_valid_o); end
    tick();  // N+4
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid got %b exp 1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_err_o !== 1'b0 || bus.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL wr_rsp_status got err=%b to=%b exp 0/0", bus.rsp_err_o, bus.rsp_timeout_o); end
    checks++; if (bus.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata got %h exp 0", bus.rsp_rdata_o); end
    checks++; if (bus.PSEL_o !== 1'b0) begin errors++; $display("FAIL wr_psel_resp got %b exp 0", bus.PSEL_o); end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    bus.PREADY_i    = 1'b0;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_rsp_drop got %b exp 0", bus.rsp_valid_o); end
  endtask

  task automatic test_read_wait();
    bit ok;
    int pen_cnt;
    bus.PRDATA_i = 32'h12345678;
    push_cmd(1'b0, 12'h010, 32'h0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_push got %b exp 1", ok); end
    wait_psel(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_psel_wait got %b exp 1", ok); end
    checks++; if (bus.PADDR_o !== 12'h010 || bus.PWRITE_o !== 1'b0) begin errors++; $display("FAIL rd_addr got %h/%b exp 010/0", bus.PADDR_o, bus.PWRITE_o); end
    tick();
    pen_cnt = 0;
    while (bus.PENABLE_o && pen_cnt < 300) begin
      pen_cnt++;
      bus.PREADY_i = (pen_cnt == 4);
      tick();
    end
    bus.PREADY_i = 1'b0;
    bus.PRDATA_i = 32'h0;
    checks++; if (pen_cnt !== 4) begin errors++; $display("FAIL rd_penable_len got %0d exp 4", pen_cnt); end
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got %b exp 1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o !== 32'h12345678) begin errors++; $display("FAIL rd_rdata got %h exp 12345678", bus.rsp_rdata_o); end
    checks++; if (bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", bus.rsp_err_o); end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_fifo_full();
    bit ok;
    int acc;
    int rises;
    int gap;
    int min_gap;
    logic prev;
    logic [11:0] seen [4];
    bus.PREADY_i = 1'b0;
    push_cmd(1'b1, 12'h0F0, 32'h0, ok);
    wait_psel(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ff_first_psel got %b exp 1", ok); end
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = 1'b1;
      bus.cmd_addr_i  = 12'h100 + 12'(acc * 16);
      bus.cmd_wdata_i = 32'(acc);
      if (bus.cmd_ready_o) acc++;
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    checks++; if (acc !== 4) begin errors++; $display("FAIL ff_accepts got %0d exp 4", acc); end
    checks++; if (bus.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL ff_ready_full got %b exp 0", bus.cmd_ready_o); end
    bus.PREADY_i    = 1'b1;
    bus.rsp_ready_i = 1'b1;
    rises = 0; gap = 0; min_gap = 1000; prev = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (bus.PSEL_o && !prev) begin
        if (rises < 4) seen[rises] = bus.PADDR_o;
        rises++;
        if (gap < min_gap) min_gap = gap;
      end
      if (!bus.PSEL_o) gap++; else gap = 0;
      prev = bus.PSEL_o;
      tick();
    end
    bus.PREADY_i    = 1'b0;
    bus.rsp_ready_i = 1'b0;
    checks++; if (rises !== 4) begin errors++; $display("FAIL ff_transfers got %0d exp 4", rises); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seen[i] !== 12'h100 + 12'(i * 16)) begin errors++; $display("FAIL ff_order[%0d] got %h exp %h", i, seen[i], 12'h100 + 12'(i * 16)); end
    end
    checks++; if (min_gap < 1) begin errors++; $display("FAIL ff_psel_gap got %0d exp >=1", min_gap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ff_drained_busy got %b exp 0", busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    bus.PREADY_i = 1'b0;
    bus.PRDATA_i = 32'hFFFFFFFF;
    push_cmd(1'b0, 12'h020, 32'h0, ok);
    wait_psel(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_psel got %b exp 1", ok); end
    tick();
    n = 0;
    while (bus.PENABLE_o && n < 400) begin
      n++;
      tick();
    end
    checks++; if (n !== 255) begin errors++; $display("FAIL to_access_len got %0d exp 255", n); end
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL to_rsp_valid got %b exp 1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_err_o !== 1'b1 || bus.rsp_timeout_o !== 1'b1) begin errors++; $display("FAIL to_status got err=%b to=%b exp 1/1", bus.rsp_err_o, bus.rsp_timeout_o); end
    checks++; if (bus.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", bus.rsp_rdata_o); end
    checks++; if (bus.PSEL_o !== 1'b0) begin errors++; $display("FAIL to_psel_drop got %b exp 0", bus.PSEL_o); end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    bus.PRDATA_i    = 32'h0;
    bus.PREADY_i    = 1'b1;
    push_cmd(1'b1, 12'h030, 32'h0000CAFE, ok);
    wait_rsp(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_next_rsp got %b exp 1", ok); end
    checks++; if (bus.rsp_err_o !== 1'b0 || bus.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL to_next_status got err=%b to=%b exp 0/0", bus.rsp_err_o, bus.rsp_timeout_o); end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    bus.PREADY_i    = 1'b0;
  endtask

  task automatic test_pslverr();
    bit ok;
    bus.PREADY_i  = 1'b1;
    bus.PSLVERR_i = 1'b1;
    bus.PRDATA_i  = 32'hA5A5A5A5;
    push_cmd(1'b0, 12'h040, 32'h0, ok);
    wait_rsp(ok);
    bus.PRDATA_i = 32'h0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL se_rsp got %b exp 1", ok); end
    checks++; if (bus.rsp_err_o !== 1'b1 || bus.rsp_timeout_o !== 1'b0) begin errors++; $display("FAIL se_status got err=%b to=%b exp 1/0", bus.rsp_err_o, bus.rsp_timeout_o); end
    checks++; if (bus.rsp_rdata_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL se_rdata got %h exp a5a5a5a5", bus.rsp_rdata_o); end
    push_cmd(1'b1, 12'h044, 32'h11112222, ok);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_rdata_o !== 32'hA5A5A5A5 || bus.PSEL_o !== 1'b0) begin
        errors++;
        $display("FAIL se_hold[%0d] got v=%b e=%b d=%h psel=%b exp 1/1/a5a5a5a5/0", c, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.PSEL_o);
      end
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    wait_rsp(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL se_wr_rsp got %b exp 1", ok); end
    checks++; if (bus.rsp_err_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL se_wr_status got err=%b d=%h exp 1/0", bus.rsp_err_o, bus.rsp_rdata_o); end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    bus.PSLVERR_i   = 1'b0;
    bus.PREADY_i    = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit psel_seen;
    bus.PREADY_i = 1'b0;
    push_cmd(1'b0, 12'h050, 32'h0, ok);
    push_cmd(1'b1, 12'h054, 32'h5, ok);
    wait_psel(ok);
    tick();
    checks++; if (bus.PENABLE_o !== 1'b1) begin errors++; $display("FAIL rm_access got %b exp 1", bus.PENABLE_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.PSEL_o !== 1'b0 || bus.PENABLE_o !== 1'b0) begin errors++; $display("FAIL rm_apb got psel=%b pen=%b exp 0/0", bus.PSEL_o, bus.PENABLE_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_rsp_busy got v=%b busy=%b exp 0/0", bus.rsp_valid_o, busy); end
    checks++; if (bus.cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rm_ready got %b exp 0", bus.cmd_ready_o); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.cmd_ready_o !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rm_after got ready=%b busy=%b exp 1/0", bus.cmd_ready_o, busy); end
    psel_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.PSEL_o || bus.rsp_valid_o) psel_seen = 1'b1;
      tick();
    end
    checks++; if (psel_seen !== 1'b0) begin errors++; $display("FAIL rm_flushed got activity=%b exp 0", psel_seen); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_write();
    test_read_wait();
    test_fifo_full();
    test_timeout();
    test_pslverr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
